// File: rtl/lcd_responder_if.sv
// Controller-side bus of the HD44780-style LCD responder: strobe, register select,
// read/write, data byte in, read data and busy flag out.
interface lcd_responder_if;
  logic       e;
  logic       rs;
  logic       rw;
  logic [7:0] lcd_data;
  logic [7:0] rd_data;
  logic       busy_flag;

  modport master (
    output e, rs, rw, lcd_data,
    input  rd_data, busy_flag
  );

  modport slave (
    input  e, rs, rw, lcd_data,
    output rd_data, busy_flag
  );
endinterface

// File: rtl/lcd_responder.sv
// HD44780-style LCD responder model: decodes controller strobes, keeps the display
// configuration and a 32-byte DDRAM, and reports busy / protocol errors.
// Optional read support is enabled by defining LCD_RESP_READ_EN.
module lcd_responder #(
  parameter int unsigned CMD_CYCLES = 120,
  parameter int unsigned CLR_CYCLES = 600,
  parameter int unsigned MIN_E_HIGH = 3
) (
  input  logic           clk,
  input  logic           rst,
  lcd_responder_if.slave bus,
  output logic           lines2,
  output logic           font5x10,
  output logic           disp_on,
  output logic           cursor_on,
  output logic           blink_on,
  output logic           inc,
  output logic           shift,
  output logic [4:0]     ddram_addr,
  output logic           wr_valid,
  output logic [7:0]     wr_char,
  input  logic [4:0]     dbg_addr,
  output logic [7:0]     dbg_char,
  output logic           proto_err
);

  localparam int unsigned MaxCycles = (CLR_CYCLES > CMD_CYCLES) ? CLR_CYCLES : CMD_CYCLES;
  localparam int unsigned BusyW     = $clog2(MaxCycles + 1);
  localparam int unsigned HiW       = $clog2(MIN_E_HIGH + 1);

  localparam logic [BusyW-1:0] CmdLoad = BusyW'(CMD_CYCLES - 1);
  localparam logic [BusyW-1:0] ClrLoad = BusyW'(CLR_CYCLES - 1);
  localparam logic [HiW-1:0]   MinHigh = HiW'(MIN_E_HIGH);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStrobe = 2'd1;
  localparam logic [1:0] StExec   = 2'd2;

`ifdef LCD_RESP_READ_EN
  localparam bit ReadEn = 1'b1;
`else
  localparam bit ReadEn = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [BusyW-1:0] busy_cnt_q, busy_cnt_d;
  logic [HiW-1:0]   hi_cnt_q, hi_cnt_d;
  logic             clr_q, clr_d;
  logic [4:0]       clr_idx_q, clr_idx_d;
  logic [4:0]       addr_q, addr_d;
  logic             inc_q, inc_d;
  logic             shift_q, shift_d;
  logic             lines2_q, lines2_d;
  logic             font_q, font_d;
  logic             disp_q, disp_d;
  logic             cursor_q, cursor_d;
  logic             blink_q, blink_d;
  logic             proto_q, proto_d;
  logic             wr_valid_q, wr_valid_d;
  logic [7:0]       wr_char_q, wr_char_d;

  logic [7:0]       mem_q [32];
  logic             mem_we;
  logic [4:0]       mem_waddr;
  logic [7:0]       mem_wdata;

  logic             fall;
  logic             wide_ok;
  logic             read_ign;
  logic [4:0]       addr_step;

  // hi_cnt_q is nonzero exactly when e was high last cycle, so this is the falling edge
  assign fall      = (hi_cnt_q != '0) && !bus.e;
  assign wide_ok   = hi_cnt_q >= MinHigh;
  assign read_ign  = bus.rw && !ReadEn;
  assign addr_step = inc_q ? addr_q + 5'd1 : addr_q - 5'd1;

  // Next-state: strobe width tracking, command decode, busy countdown and clear sweep
  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    clr_d      = clr_q;
    clr_idx_d  = clr_idx_q;
    addr_d     = addr_q;
    inc_d      = inc_q;
    shift_d    = shift_q;
    lines2_d   = lines2_q;
    font_d     = font_q;
    disp_d     = disp_q;
    cursor_d   = cursor_q;
    blink_d    = blink_q;
    proto_d    = proto_q;
    wr_valid_d = 1'b0;
    wr_char_d  = wr_char_q;
    mem_we     = 1'b0;
    mem_waddr  = addr_q;
    mem_wdata  = bus.lcd_data;

    hi_cnt_d = '0;
    if (bus.e) begin
      hi_cnt_d = (hi_cnt_q < MinHigh) ? hi_cnt_q + 1'b1 : hi_cnt_q;
    end

    case (state_q)
      StIdle, StStrobe: begin
        state_d = bus.e ? StStrobe : StIdle;
        // Idle also handles a fall so a poll strobe that outlives EXEC is not lost
        if (fall && !read_ign) begin
          if (!wide_ok) begin
            proto_d = 1'b1;
          end else if (bus.rw) begin
            if (bus.rs) addr_d = addr_step;
          end else begin
            state_d    = StExec;
            busy_cnt_d = CmdLoad;
            if (bus.rs) begin
              mem_we     = 1'b1;
              wr_valid_d = 1'b1;
              wr_char_d  = bus.lcd_data;
              addr_d     = addr_step;
            end else if (bus.lcd_data[7]) begin
              addr_d = bus.lcd_data[4:0];
            end else if (bus.lcd_data[6:5] == 2'b01) begin
              // Bit 4 selects bus width on a real panel and has no effect here
              lines2_d = bus.lcd_data[3];
              font_d   = bus.lcd_data[2];
            end else if (bus.lcd_data[6:3] == 4'b0001) begin
              disp_d   = bus.lcd_data[2];
              cursor_d = bus.lcd_data[1];
              blink_d  = bus.lcd_data[0];
            end else if (bus.lcd_data[6:2] == 5'b00001) begin
              inc_d   = bus.lcd_data[1];
              shift_d = bus.lcd_data[0];
            end else if (bus.lcd_data == 8'h01) begin
              busy_cnt_d = ClrLoad;
              clr_d      = 1'b1;
              clr_idx_d  = 5'd0;
              addr_d     = 5'd0;
              inc_d      = 1'b1;
            end
          end
        end
      end
      StExec: begin
        if (busy_cnt_q == '0) begin
          state_d = StIdle;
          clr_d   = 1'b0;
        end else begin
          busy_cnt_d = busy_cnt_q - 1'b1;
        end
        if (clr_q) begin
          mem_we    = 1'b1;
          mem_waddr = clr_idx_q;
          mem_wdata = 8'h20;
          clr_idx_d = clr_idx_q + 5'd1;
          if (clr_idx_q == 5'd31) clr_d = 1'b0;
        end
        // Reads while busy are polls and have no side effect; writes are dropped
        if (fall && !read_ign && (!bus.rw || !wide_ok)) proto_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control, configuration and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      busy_cnt_q <= '0;
      hi_cnt_q   <= '0;
      clr_q      <= 1'b0;
      clr_idx_q  <= 5'd0;
      addr_q     <= 5'd0;
      inc_q      <= 1'b1;
      shift_q    <= 1'b0;
      lines2_q   <= 1'b0;
      font_q     <= 1'b0;
      disp_q     <= 1'b0;
      cursor_q   <= 1'b0;
      blink_q    <= 1'b0;
      proto_q    <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_char_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      hi_cnt_q   <= hi_cnt_d;
      clr_q      <= clr_d;
      clr_idx_q  <= clr_idx_d;
      addr_q     <= addr_d;
      inc_q      <= inc_d;
      shift_q    <= shift_d;
      lines2_q   <= lines2_d;
      font_q     <= font_d;
      disp_q     <= disp_d;
      cursor_q   <= cursor_d;
      blink_q    <= blink_d;
      proto_q    <= proto_d;
      wr_valid_q <= wr_valid_d;
      wr_char_q  <= wr_char_d;
    end
  end

  // DDRAM storage; deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

`ifdef LCD_RESP_READ_EN
  logic [7:0] rd_q;

  // Read response, registered and held at zero outside a read strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= 8'h00;
    end else if (bus.e && bus.rw) begin
      rd_q <= bus.rs ? mem_q[addr_q] : {state_q == StExec, 2'b00, addr_q};
    end else begin
      rd_q <= 8'h00;
    end
  end

  assign bus.rd_data = rd_q;
`else
  assign bus.rd_data = 8'h00;
`endif

  assign bus.busy_flag = (state_q == StExec);
  assign lines2        = lines2_q;
  assign font5x10      = font_q;
  assign disp_on       = disp_q;
  assign cursor_on     = cursor_q;
  assign blink_on      = blink_q;
  assign inc           = inc_q;
  assign shift         = shift_q;
  assign ddram_addr    = addr_q;
  assign wr_valid      = wr_valid_q;
  assign wr_char       = wr_char_q;
  assign proto_err     = proto_q;
  assign dbg_char      = mem_q[dbg_addr];

endmodule

// File: tb/tb_lcd_responder.sv
// Self-checking bench for lcd_responder: busy lengths and written bytes are predicted
// into queues when strobes are driven and retired by a monitor as the DUT responds.
module tb_lcd_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lines2, font5x10, disp_on, cursor_on, blink_on, inc, shift;
  logic [4:0] ddram_addr;
  logic       wr_valid;
  logic [7:0] wr_char;
  logic [4:0] dbg_addr;
  logic [7:0] dbg_char;
  logic       proto_err;
  logic [7:0] rd;

  int n_vec = 0;
  int n_bad = 0;

  int unsigned exp_busy[$];
  logic [7:0]  exp_wr[$];

  lcd_responder_if bus ();

  lcd_responder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .lines2    (lines2),
    .font5x10  (font5x10),
    .disp_on   (disp_on),
    .cursor_on (cursor_on),
    .blink_on  (blink_on),
    .inc       (inc),
    .shift     (shift),
    .ddram_addr(ddram_addr),
    .wr_valid  (wr_valid),
    .wr_char   (wr_char),
    .dbg_addr  (dbg_addr),
    .dbg_char  (dbg_char),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Strobe held high for 'width' sampled cycles, data held through the falling edge
  task automatic strobe(input logic s, input logic w, input logic [7:0] d, input int width);
    @(negedge clk);
    bus.rs = s;
    bus.rw = w;
    bus.lcd_data = d;
    bus.e = 1'b1;
    repeat (width) @(negedge clk);
    bus.e = 1'b0;
    @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] d, input int unsigned cycles);
    exp_busy.push_back(cycles);
    strobe(1'b0, 1'b0, d, 5);
  endtask

  task automatic data_wr(input logic [7:0] d);
    exp_busy.push_back(120);
    exp_wr.push_back(d);
    strobe(1'b1, 1'b0, d, 5);
  endtask

  // Read strobe of width 5, rd_data sampled while e is still high
  task automatic strobe_rd(input logic s, output logic [7:0] r);
    @(negedge clk);
    bus.rs = s;
    bus.rw = 1'b1;
    bus.lcd_data = 8'h00;
    bus.e = 1'b1;
    repeat (4) @(negedge clk);
    r = bus.rd_data;
    @(negedge clk);
    bus.e = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      if (!bus.busy_flag) break;
      @(negedge clk);
    end
    check("idle_timeout", bus.busy_flag, 1'b0);
  endtask

  // Monitor: retires predicted busy lengths and written bytes
  initial begin
    int   bcnt;
    logic wr_prev;
    bcnt = 0;
    wr_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bcnt = 0;
        wr_prev = 1'b0;
      end else begin
        if (bus.busy_flag) begin
          bcnt++;
        end else if (bcnt != 0) begin
          if (exp_busy.size() == 0) check("busy_unexpected", exp_busy.size(), 1);
          else check("busy_len", bcnt, exp_busy.pop_front());
          bcnt = 0;
        end
        if (wr_valid) begin
          check("wr_pulse", wr_prev, 1'b0);
          if (exp_wr.size() == 0) check("wr_unexpected", exp_wr.size(), 1);
          else check("wr_char", wr_char, exp_wr.pop_front());
        end
        wr_prev = wr_valid;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    bus.e = 1'b0;
    bus.rs = 1'b0;
    bus.rw = 1'b0;
    bus.lcd_data = 8'h00;
    dbg_addr = 5'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cfg", {lines2, font5x10, disp_on, cursor_on, blink_on, inc, shift}, 7'b0000010);
    check("rst_flags", {bus.busy_flag, proto_err, wr_valid}, 3'b000);
    check("rst_addr", ddram_addr, 5'd0);
    check("rst_rd", bus.rd_data, 8'h00);
    rst = 1'b0;

    // Function set with a long strobe
    exp_busy.push_back(120);
    strobe(1'b0, 1'b0, 8'h38, 39);
    check("fset", {lines2, font5x10}, 2'b10);
    check("fset_busy", bus.busy_flag, 1'b1);
    wait_idle();

    // Clear fills DDRAM with spaces
    cmd(8'h01, 600);
    wait_idle();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check("clr_fill", dbg_char, 8'h20);
    end
    check("clr_addr", ddram_addr, 5'd0);
    check("clr_inc", inc, 1'b1);

    // Increment-mode write wraps 31 -> 0, decrement-mode write wraps 0 -> 31
    cmd(8'h06, 120);
    wait_idle();
    check("entry_inc", {inc, shift}, 2'b10);
    cmd(8'h9F, 120);
    wait_idle();
    check("set_addr", ddram_addr, 5'd31);
    data_wr(8'h41);
    check("wr_wrap_up", ddram_addr, 5'd0);
    wait_idle();
    dbg_addr = 5'd31;
    #1;
    check("ddram31", dbg_char, 8'h41);
    cmd(8'h04, 120);
    wait_idle();
    check("entry_dec", {inc, shift}, 2'b00);
    data_wr(8'h42);
    check("wr_wrap_dn", ddram_addr, 5'd31);
    wait_idle();
    dbg_addr = 5'd0;
    #1;
    check("ddram0", dbg_char, 8'h42);

    // Short strobe is discarded with an error
    strobe(1'b0, 1'b0, 8'h0F, 2);
    check("short_err", proto_err, 1'b1);
    check("short_busy", bus.busy_flag, 1'b0);
    check("short_disp", disp_on, 1'b0);

    // Reset clears the sticky error but keeps DDRAM
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_err", proto_err, 1'b0);
    check("rst2_mode", {ddram_addr, inc}, {5'd0, 1'b1});
    rst = 1'b0;
    dbg_addr = 5'd31;
    #1;
    check("ddram_kept", dbg_char, 8'h41);

    // Reads: busy poll and data read
    cmd(8'h85, 120);
    check("addr5", ddram_addr, 5'd5);
    strobe_rd(1'b0, rd);
`ifdef LCD_RESP_READ_EN
    check("poll_busy", rd, 8'h85);
`else
    check("poll_busy", rd, 8'h00);
`endif
    check("poll_err", proto_err, 1'b0);
    wait_idle();
    strobe_rd(1'b0, rd);
`ifdef LCD_RESP_READ_EN
    check("poll_idle", rd, 8'h05);
`else
    check("poll_idle", rd, 8'h00);
`endif
    strobe_rd(1'b1, rd);
`ifdef LCD_RESP_READ_EN
    check("data_rd", rd, 8'h20);
    check("rd_step", ddram_addr, 5'd6);
`else
    check("data_rd", rd, 8'h00);
    check("rd_step", ddram_addr, 5'd5);
`endif
    check("rd_err", proto_err, 1'b0);

    // Write during busy is dropped and flagged; countdown unaffected
    cmd(8'h80, 120);
    strobe(1'b0, 1'b0, 8'h0F, 5);
    check("busy_wr_err", proto_err, 1'b1);
    check("busy_wr_drop", {disp_on, cursor_on, blink_on}, 3'b000);
    wait_idle();
    check("busy_wr_addr", ddram_addr, 5'd0);

    // Reset in the middle of a clear aborts it at once
    strobe(1'b0, 1'b0, 8'h01, 5);
    repeat (298) @(negedge clk);
    check("clr_mid_busy", bus.busy_flag, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("clr_abort", bus.busy_flag, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cmd(8'h0C, 120);
    check("after_abort", {disp_on, cursor_on, blink_on}, 3'b100);
    check("after_busy", bus.busy_flag, 1'b1);
    wait_idle();

    repeat (3) @(negedge clk);
    check("busy_q_empty", exp_busy.size(), 0);
    check("wr_q_empty", exp_wr.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
